instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
Parametrised instruction memory for the pipeline IF stage, with an integrated program loader for the debug unit. The fetch port is read on the falling clock edge. The debug unit streams a program in byte-serial form over a valid/ready handshake; a loader FSM clears the array, assembles bytes into words, and writes consecutive addresses. The block reports load progress, overflow/partial-word errors and out-of-range fetches, and offers a debug readback port.

Parameters:
DATA_W, 32, instruction word width; must be a multiple of 8.
DEPTH, 64, number of words.
ADDR_W, 32, width of the fetch and debug word-index addresses.
localparam NB = DATA_W/8, bytes per word; CNT_W = $clog2(DEPTH)+1.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
en  in  1  fetch enable; 0 = stall, hold rd_data.
rd_addr  in  ADDR_W  fetch word index (PC).
rd_data  out  DATA_W  fetched instruction.
rd_valid  out  1  rd_data is a real fetch from a loaded memory.
rd_err  out  1  last fetch address was >= DEPTH.
ld_start  in  1  pulse: begin a clear+load session.
ld_byte  in  8  program byte, MSB-first within each word.
ld_byte_valid  in  1  ld_byte is valid.
ld_ready  out  1  loader accepts a byte this cycle.
ld_end  in  1  pulse: end of program stream.
ld_busy  out  1  clear or load in progress.
ld_count  out  CNT_W  words written in the current/last session.
ld_err  out  1  sticky: overflow or partial word at end.
dbg_addr  in  ADDR_W  debug readback word index.
dbg_data  out  DATA_W  registered readback; 0 if out of range.

Behaviour:
- FSM states: CLEAR, LOAD, IDLE. Loader logic runs on the rising edge; the fetch port is registered on the falling edge.
- Reset (async): state=CLEAR, clr_ptr=0, byte_cnt=0, ld_count=0, ld_err=0, ld_busy=1, ld_ready=0, rd_data=0, rd_valid=0, rd_err=0, dbg_data=0. Array contents are not reset asynchronously.
- CLEAR: write 0 to word clr_ptr once per rising edge. After writing DEPTH-1, go to LOAD. This takes exactly DEPTH cycles.
- Leaving reset (not ld_start), CLEAR goes to IDLE instead of LOAD, so the array is zeroed with a loaded flag of 0.
- IDLE: ld_busy=0, ld_ready=0.
  - ld_start=1: ld_count=0, ld_err=0, byte_cnt=0, clr_ptr=0, loaded=0, go to CLEAR.
  - ld_start while ld_busy=1 is ignored.
- LOAD: ld_ready=1 and ld_busy=1.
  - Handshake: a byte transfers when ld_byte_valid && ld_ready.
  - Transferred bytes shift into assembly register asm = {asm[DATA_W-9:0], ld_byte}; byte_cnt increments.
  - On the NB-th byte, write the word to address ld_count and increment ld_count. The write takes effect that edge and is visible to fetch from the next falling edge.
  - If ld_count == DEPTH when a word completes, drop the word and set ld_err; ld_count saturates at DEPTH.
  - ld_end: a byte transferred in the same cycle is accepted first. If byte_cnt != 0 after that byte, discard the partial word and set ld_err. Then set loaded=1 and go to IDLE.
- Fetch (falling edge):
  - If ld_busy or !loaded: rd_data=0 (NOP), rd_valid=0.
  - Else if en=0: hold rd_data, rd_valid and rd_err.
  - Else if rd_addr >= DEPTH: rd_data=0, rd_err=1, rd_valid=1.
  - Else: rd_data=mem[rd_addr], rd_err=0, rd_valid=1.
- Debug readback: dbg_data <= mem[dbg_addr] on the rising edge in every state; 0 if dbg_addr >= DEPTH.
- rst asserted mid-load: the session is aborted, the FSM enters CLEAR, and the loaded program is lost.
- Compare widths: rd_addr and dbg_addr are compared at full ADDR_W. Upper bits are never truncated, so aliasing is not allowed.

Test Plan:
1. Reset, then wait 64 cycles → ld_busy falls at cycle 64. dbg_addr sweep 0..63 returns 0 everywhere; rd_valid=0.
2. ld_start, wait 64 cycles for CLEAR; send bytes 20,01,00,08, 20,02,00,03, then ld_end → ld_count=2, ld_err=0. Fetch addr 0 → 0x20010008; fetch addr 1 → 0x20020003; rd_valid=1.
3. Toggle ld_byte_valid randomly during a 3-word load, with en=0 for 4 cycles mid-fetch → words are correct and rd_data holds during stall.
4. Load 65 words (260 bytes) → ld_count=64, ld_err=1, mem[63] = 64th word.
5. Send 6 bytes then ld_end with a 7th byte in the same cycle → ld_count=1, ld_err=1, only word 0 is written. Fetch rd_addr=64 → rd_err=1, rd_data=0.
6. Assert rst mid-LOAD after 2 words → all outputs take reset values; after 64 cycles mem reads 0 and rd_valid=0.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Instruction memory for the IF stage with an integrated byte-serial program
// loader. The loader runs on the rising edge; the fetch port is registered on
// the falling edge so the pipeline sees the instruction within the same cycle.
module instr_mem_loader #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic [ADDR_W-1:0]              rd_addr,
   output logic [DATA_W-1:0]              rd_data,
   output logic                           rd_valid,
   output logic                           rd_err,
   input  logic                           ld_start,
   input  logic [7:0]                     ld_byte,
   input  logic                           ld_byte_valid,
   output logic                           ld_ready,
   input  logic                           ld_end,
   output logic                           ld_busy,
   output logic [$clog2(DEPTH):0]         ld_count,
   output logic                           ld_err,
   input  logic [ADDR_W-1:0]              dbg_addr,
   output logic [DATA_W-1:0]              dbg_data
);

   localparam int NB    = DATA_W / 8;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BW    = (NB > 1) ? $clog2(NB) : 1;

   localparam logic [1:0] CLEAR = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] IDLE  = 2'd2;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [1:0]        state;
   logic [AW-1:0]     clr_ptr;
   logic [BW-1:0]     byte_cnt;
   logic [DATA_W-1:0] asm_word;
   logic              loaded;
   // set by ld_start so that the following CLEAR hands over to LOAD, not IDLE
   logic              load_pending;

   logic              xfer;
   logic              word_done;
   logic              full;
   logic              clr_last;
   logic [DATA_W+7:0] cat_word;
   logic [DATA_W-1:0] asm_next;
   logic [BW-1:0]     byte_cnt_after;
   logic              we;
   logic [AW-1:0]     wa;
   logic [DATA_W-1:0] wd;

   assign xfer      = ld_ready && ld_byte_valid;
   assign cat_word  = {asm_word, ld_byte};
   assign asm_next  = cat_word[DATA_W-1:0];
   assign word_done = xfer && (byte_cnt == BW'(NB - 1));
   assign full      = (ld_count == CNT_W'(DEPTH));
   assign clr_last  = (clr_ptr == AW'(DEPTH - 1));

   // byte position after this cycle's transfer, used for the partial-word check at ld_end
   always_comb begin
      byte_cnt_after = byte_cnt;
      if (word_done) begin
         byte_cnt_after = '0;
      end else if (xfer) begin
         byte_cnt_after = byte_cnt + BW'(1);
      end else begin
         byte_cnt_after = byte_cnt;
      end
   end

   // array write port: zero fill during CLEAR, assembled words during LOAD
   always_comb begin
      we = 1'b0;
      wa = clr_ptr;
      wd = '0;
      case (state)
         CLEAR: begin
            we = 1'b1;
         end
         LOAD: begin
            if (word_done && !full) begin
               we = 1'b1;
               wa = ld_count[AW-1:0];
               wd = asm_next;
            end else begin
               we = 1'b0;
            end
         end
         default: begin
            we = 1'b0;
         end
      endcase
   end

   // memory array; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wa] <= wd;
      end
   end

   // loader FSM: clear sweep, byte assembly, session bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= CLEAR;
         clr_ptr      <= '0;
         byte_cnt     <= '0;
         asm_word     <= '0;
         loaded       <= 1'b0;
         load_pending <= 1'b0;
         ld_count     <= '0;
         ld_err       <= 1'b0;
         ld_busy      <= 1'b1;
         ld_ready     <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               clr_ptr <= clr_ptr + AW'(1);
               if (clr_last) begin
                  clr_ptr      <= '0;
                  state        <= load_pending ? LOAD : IDLE;
                  ld_busy      <= load_pending;
                  ld_ready     <= load_pending;
                  load_pending <= 1'b0;
               end
            end
            LOAD: begin
               if (xfer) begin
                  asm_word <= asm_next;
                  byte_cnt <= byte_cnt_after;
               end
               if (word_done) begin
                  if (full) begin
                     ld_err <= 1'b1;
                  end else begin
                     ld_count <= ld_count + CNT_W'(1);
                  end
               end
               if (ld_end) begin
                  if (byte_cnt_after != '0) begin
                     ld_err <= 1'b1;
                  end
                  byte_cnt <= '0;
                  loaded   <= 1'b1;
                  state    <= IDLE;
                  ld_busy  <= 1'b0;
                  ld_ready <= 1'b0;
               end
            end
            IDLE: begin
               if (ld_start) begin
                  ld_count     <= '0;
                  ld_err       <= 1'b0;
                  byte_cnt     <= '0;
                  clr_ptr      <= '0;
                  loaded       <= 1'b0;
                  load_pending <= 1'b1;
                  state        <= CLEAR;
                  ld_busy      <= 1'b1;
                  ld_ready     <= 1'b0;
               end
            end
            default: begin
               state    <= CLEAR;
               clr_ptr  <= '0;
               ld_busy  <= 1'b1;
               ld_ready <= 1'b0;
            end
         endcase
      end
   end

   // fetch port on the falling edge: NOP while loading, hold on stall, flag out-of-range
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
      end else if (ld_busy || !loaded) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
      end else if (!en) begin
         rd_data  <= rd_data;
         rd_valid <= rd_valid;
         rd_err   <= rd_err;
      end else if (rd_addr >= ADDR_W'(DEPTH)) begin
         rd_data  <= '0;
         rd_valid <= 1'b1;
         rd_err   <= 1'b1;
      end else begin
         rd_data  <= mem[rd_addr[AW-1:0]];
         rd_valid <= 1'b1;
         rd_err   <= 1'b0;
      end
   end

   // debug readback, full-width range check so upper address bits never alias
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbg_data <= '0;
      end else if (dbg_addr >= ADDR_W'(DEPTH)) begin
         dbg_data <= '0;
      end else begin
         dbg_data <= mem[dbg_addr[AW-1:0]];
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: reset sweep, table-driven fetch/debug
// vectors after a two-word program, plus hand sequences for stalls, overflow,
// partial words and reset during a load.
module tb_instr_mem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] rd_addr;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        rd_err;
   logic        ld_start;
   logic [7:0]  ld_byte;
   logic        ld_byte_valid;
   logic        ld_ready;
   logic        ld_end;
   logic        ld_busy;
   logic [6:0]  ld_count;
   logic        ld_err;
   logic [31:0] dbg_addr;
   logic [31:0] dbg_data;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        err;
   } fvec_t;

   fvec_t tab [7];

   instr_mem_loader dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .rd_err        (rd_err),
      .ld_start      (ld_start),
      .ld_byte       (ld_byte),
      .ld_byte_valid (ld_byte_valid),
      .ld_ready      (ld_ready),
      .ld_end        (ld_end),
      .ld_busy       (ld_busy),
      .ld_count      (ld_count),
      .ld_err        (ld_err),
      .dbg_addr      (dbg_addr),
      .dbg_data      (dbg_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      ld_byte       = b;
      ld_byte_valid = 1'b1;
      tick();
      ld_byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
   endtask

   task automatic end_load();
      ld_end = 1'b1;
      tick();
      ld_end = 1'b0;
   endtask

   // pulse ld_start and wait (bounded) for CLEAR to hand over to LOAD
   task automatic start_load();
      int n;
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      n = 0;
      while (!ld_ready && n < 200) begin
         tick();
         n++;
      end
      check("start_ready", {31'd0, ld_ready}, 32'd1);
      check("start_cycles", n, 32'd64);
   endtask

   task automatic fetch(input logic [31:0] a);
      en      = 1'b1;
      rd_addr = a;
      tick();
   endtask

   initial begin
      tab[0] = '{32'd0,           32'h2001_0008, 1'b0};
      tab[1] = '{32'd1,           32'h2002_0003, 1'b0};
      tab[2] = '{32'd2,           32'h0000_0000, 1'b0};
      tab[3] = '{32'd63,          32'h0000_0000, 1'b0};
      tab[4] = '{32'd64,          32'h0000_0000, 1'b1};
      tab[5] = '{32'h0000_0041,   32'h0000_0000, 1'b1};
      tab[6] = '{32'h1000_0000,   32'h0000_0000, 1'b1};

      rst = 1'b1; en = 1'b0; rd_addr = '0; ld_start = 1'b0; ld_byte = '0;
      ld_byte_valid = 1'b0; ld_end = 1'b0; dbg_addr = '0;

      // 1: reset values, CLEAR length, zeroed array
      repeat (3) tick();
      check("rst_busy",     {31'd0, ld_busy},  32'd1);
      check("rst_ready",    {31'd0, ld_ready}, 32'd0);
      check("rst_count",    {25'd0, ld_count}, 32'd0);
      check("rst_err",      {31'd0, ld_err},   32'd0);
      check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      check("rst_rd_data",  rd_data,           32'd0);
      check("rst_dbg",      dbg_data,          32'd0);
      rst = 1'b0;
      repeat (63) tick();
      check("clear_busy_63", {31'd0, ld_busy}, 32'd1);
      tick();
      check("clear_busy_64", {31'd0, ld_busy}, 32'd0);
      check("idle_ready",    {31'd0, ld_ready}, 32'd0);
      for (int a = 0; a < 64; a++) begin
         dbg_addr = a;
         fetch(a);
         check("sweep_dbg", dbg_data, 32'd0);
      end
      check("sweep_rd_valid", {31'd0, rd_valid}, 32'd0);

      // 2: two-word program, table-driven fetch and debug readback
      start_load();
      send_word(32'h2001_0008);
      send_word(32'h2002_0003);
      end_load();
      check("t2_count", {25'd0, ld_count}, 32'd2);
      check("t2_err",   {31'd0, ld_err},   32'd0);
      check("t2_busy",  {31'd0, ld_busy},  32'd0);
      for (int i = 0; i < 7; i++) begin
         dbg_addr = tab[i].addr;
         fetch(tab[i].addr);
         check("t2_rd_data",  rd_data,           tab[i].data);
         check("t2_rd_err",   {31'd0, rd_err},   {31'd0, tab[i].err});
         check("t2_rd_valid", {31'd0, rd_valid}, 32'd1);
         check("t2_dbg",      dbg_data,          tab[i].data);
      end

      // 3: gapped byte stream, then a fetch stall
      start_load();
      begin
         logic [31:0] w3 [3];
         w3[0] = 32'hDEAD_BEEF; w3[1] = 32'h0123_4567; w3[2] = 32'hA5A5_5A5A;
         for (int i = 0; i < 3; i++) begin
            for (int k = 3; k >= 0; k--) begin
               repeat ($urandom_range(0, 2)) begin
                  ld_byte = 8'($urandom);
                  tick();
               end
               send_byte(w3[i][8*k +: 8]);
            end
         end
      end
      end_load();
      check("t3_count", {25'd0, ld_count}, 32'd3);
      check("t3_err",   {31'd0, ld_err},   32'd0);
      fetch(32'd0);
      check("t3_w0", rd_data, 32'hDEAD_BEEF);
      fetch(32'd1);
      check("t3_w1", rd_data, 32'h0123_4567);
      en = 1'b0;
      rd_addr = 32'd2;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t3_stall_hold", rd_data, 32'h0123_4567);
      end
      fetch(32'd2);
      check("t3_w2", rd_data, 32'hA5A5_5A5A);
      fetch(32'd3);
      check("t3_w3", rd_data, 32'h0000_0000);

      // 4: overflow with 65 words
      start_load();
      for (int w = 0; w < 64; w++) send_word({8'(w), 8'h5A, 8'hC3, 8'(w + 1)});
      check("t4_count_64",  {25'd0, ld_count}, 32'd64);
      check("t4_err_64",    {31'd0, ld_err},   32'd0);
      send_word(32'hFFFF_FFFF);
      end_load();
      check("t4_count_sat", {25'd0, ld_count}, 32'd64);
      check("t4_err_ovf",   {31'd0, ld_err},   32'd1);
      fetch(32'd0);
      check("t4_w0", rd_data, 32'h005A_C301);
      fetch(32'd63);
      check("t4_w63", rd_data, 32'h3F5A_C340);

      // 5: partial word at end, ld_start ignored while loading
      start_load();
      send_word(32'h1122_3344);
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      check("t5_start_ignored_cnt", {25'd0, ld_count}, 32'd1);
      check("t5_start_ignored_rdy", {31'd0, ld_ready}, 32'd1);
      send_byte(8'h55);
      send_byte(8'h66);
      ld_byte = 8'h77;
      ld_byte_valid = 1'b1;
      ld_end = 1'b1;
      tick();
      ld_byte_valid = 1'b0;
      ld_end = 1'b0;
      check("t5_count", {25'd0, ld_count}, 32'd1);
      check("t5_err",   {31'd0, ld_err},   32'd1);
      check("t5_busy",  {31'd0, ld_busy},  32'd0);
      fetch(32'd0);
      check("t5_w0", rd_data, 32'h1122_3344);
      fetch(32'd1);
      check("t5_w1", rd_data, 32'h0000_0000);
      fetch(32'd64);
      check("t5_oor_err",   {31'd0, rd_err},   32'd1);
      check("t5_oor_data",  rd_data,           32'd0);
      check("t5_oor_valid", {31'd0, rd_valid}, 32'd1);

      // 6: reset in the middle of a load
      start_load();
      send_word(32'hCAFE_0001);
      send_word(32'hCAFE_0002);
      check("t6_count_pre", {25'd0, ld_count}, 32'd2);
      dbg_addr = 32'd0;
      rst = 1'b1;
      #1;
      check("t6_rst_busy",  {31'd0, ld_busy},  32'd1);
      check("t6_rst_ready", {31'd0, ld_ready}, 32'd0);
      check("t6_rst_count", {25'd0, ld_count}, 32'd0);
      check("t6_rst_err",   {31'd0, ld_err},   32'd0);
      check("t6_rst_valid", {31'd0, rd_valid}, 32'd0);
      check("t6_rst_dbg",   dbg_data,          32'd0);
      tick();
      rst = 1'b0;
      repeat (64) tick();
      check("t6_busy_done", {31'd0, ld_busy}, 32'd0);
      for (int a = 0; a < 2; a++) begin
         dbg_addr = a;
         fetch(a);
         check("t6_dbg_zero", dbg_data,          32'd0);
         check("t6_rd_data",  rd_data,           32'd0);
         check("t6_rd_valid", {31'd0, rd_valid}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
